// File: rtl/turn_sequencer_pkg.sv
// Shared types and helpers for the game-turn controller: FSM state encoding,
// default tile width and a constant-friendly ceiling-log2.
package chacha_pkg;

    localparam int TILE_W_DEF = 4;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WAIT_PICK = 4'd1,
        ST_LOAD_CTR  = 4'd2,
        ST_FETCH     = 4'd3,
        ST_LOAD_EDGE = 4'd4,
        ST_SETTLE    = 4'd5,
        ST_CHECK     = 4'd6,
        ST_REVEAL    = 4'd7,
        ST_MOVE      = 4'd8,
        ST_PASS      = 4'd9,
        ST_WIN       = 4'd10
    } state_t;

    // Bits needed to index v distinct values; never less than 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/turn_sequencer_cycle_timer.sv
// Down-counter shared by the reveal hold and the pick timeout: load a
// count, decrement while run is high, done when the count reaches zero.
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         run,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/turn_sequencer.sv
// Game-turn controller sequencing check_same through pick, edge fetch, compare,
// reveal and move/pass. Optional pick timeout enabled by TURN_TIMEOUT_EN.
module turn_sequencer
    import chacha_pkg::*;
#(
    parameter  int NUM_PLAYERS = 2,
    parameter  int BOARD_LEN   = 24,
    parameter  int TILE_W      = TILE_W_DEF,
    parameter  int SHOW_CYCLES = 50_000_000,
    parameter  int TIMEOUT_CYC = 500_000_000,
    localparam int POS_W       = clog2(BOARD_LEN),
    localparam int PL_W        = clog2(NUM_PLAYERS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         pick_valid,
    input  logic [TILE_W-1:0]            pick_tile,
    output logic [POS_W-1:0]             edge_addr,
    input  logic [TILE_W-1:0]            edge_tile,
    output logic [TILE_W-1:0]            cmp_data,
    output logic                         cmp_sel,
    input  logic                         cmp_match,
    output logic [PL_W-1:0]              cur_player,
    output logic [NUM_PLAYERS*POS_W-1:0] pos_flat,
    output logic                         show,
    output logic                         winner_valid,
    output logic [PL_W-1:0]              winner
);

    localparam int STEP_W  = clog2(BOARD_LEN + 1);
    // Timer is sized for the longer of the two hold times it may be loaded with.
    localparam int TMR_MAX = (SHOW_CYCLES > TIMEOUT_CYC) ? SHOW_CYCLES : TIMEOUT_CYC;
    localparam int TMR_W   = clog2(TMR_MAX + 1);

    state_t              state;
    logic [POS_W-1:0]    pos   [NUM_PLAYERS];
    logic [STEP_W-1:0]   steps [NUM_PLAYERS];
    logic [TILE_W-1:0]   edge_q;
    logic                match_q;
    logic                tmr_load;
    logic                tmr_run;
    logic [TMR_W-1:0]    tmr_val;
    logic                tmr_done;
    logic [STEP_W-1:0]   steps_nxt;

    function automatic logic [POS_W-1:0] pos_inc(input logic [POS_W-1:0] p);
        return (p == POS_W'(BOARD_LEN - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [POS_W-1:0] init_pos(input int p);
        return POS_W'(p * (BOARD_LEN / NUM_PLAYERS));
    endfunction

    assign steps_nxt = steps[cur_player] + STEP_W'(1);

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_flat
        assign pos_flat[g*POS_W +: POS_W] = pos[g];
    end

    always_comb begin
        tmr_load = 1'b0;
        tmr_run  = 1'b0;
        tmr_val  = TMR_W'(SHOW_CYCLES - 1);
        case (state)
            ST_CHECK:     tmr_load = 1'b1;
            ST_REVEAL:    tmr_run  = 1'b1;
`ifdef TURN_TIMEOUT_EN
            ST_WAIT_PICK: tmr_run  = 1'b1;
            // Every other state keeps the timeout preloaded, so it restarts
            // from full on each entry into WAIT_PICK.
            default: begin
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(TIMEOUT_CYC - 1);
            end
`else
            default: ;
`endif
        endcase
    end

    cycle_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .run      (tmr_run),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cur_player   <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                pos[p]   <= init_pos(p);
                steps[p] <= '0;
            end
            edge_q       <= '0;
            match_q      <= 1'b0;
            cmp_sel      <= 1'b1;
            cmp_data     <= '0;
            edge_addr    <= '0;
            show         <= 1'b0;
            winner_valid <= 1'b0;
            winner       <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_WIN: begin
                    if (start) begin
                        cur_player <= '0;
                        for (int p = 0; p < NUM_PLAYERS; p++) begin
                            pos[p]   <= init_pos(p);
                            steps[p] <= '0;
                        end
                        winner_valid <= 1'b0;
                        winner       <= '0;
                        state        <= ST_WAIT_PICK;
                    end
                end
                ST_WAIT_PICK: begin
                    if (pick_valid) begin
                        cmp_sel  <= 1'b0;
                        cmp_data <= pick_tile;
                        state    <= ST_LOAD_CTR;
`ifdef TURN_TIMEOUT_EN
                    end else if (tmr_done) begin
                        state    <= ST_PASS;
`endif
                    end
                end
                ST_LOAD_CTR: begin
                    cmp_sel   <= 1'b1;
                    cmp_data  <= edge_q;
                    edge_addr <= pos_inc(pos[cur_player]);
                    state     <= ST_FETCH;
                end
                ST_FETCH: state <= ST_LOAD_EDGE;
                ST_LOAD_EDGE: begin
                    edge_q   <= edge_tile;
                    cmp_data <= edge_tile;
                    state    <= ST_SETTLE;
                end
                ST_SETTLE: state <= ST_CHECK;
                ST_CHECK: begin
                    match_q <= cmp_match;
                    show    <= 1'b1;
                    state   <= ST_REVEAL;
                end
                ST_REVEAL: begin
                    if (tmr_done) begin
                        show  <= 1'b0;
                        state <= match_q ? ST_MOVE : ST_PASS;
                    end
                end
                ST_MOVE: begin
                    pos[cur_player]   <= pos_inc(pos[cur_player]);
                    steps[cur_player] <= steps_nxt;
                    if (steps_nxt == STEP_W'(BOARD_LEN)) begin
                        winner       <= cur_player;
                        winner_valid <= 1'b1;
                        state        <= ST_WIN;
                    end else begin
                        state        <= ST_WAIT_PICK;
                    end
                end
                ST_PASS: begin
                    cur_player <= (cur_player == PL_W'(NUM_PLAYERS - 1)) ? '0 : cur_player + 1'b1;
                    state      <= ST_WAIT_PICK;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
